// File: rtl/pattern_chain_pipe_if.sv
// Handshake and data bundle for pattern_chain_pipe: the input beat side
// (in_valid/in_ready, a..d, mode) and the output beat side (out_valid/out_ready, w..z).
// slave = pipe view (consumes in_*, produces out_*); master = source/sink view.
interface pattern_chain_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_w;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_z;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_mode, out_ready,
    input  in_ready, out_valid, out_w, out_x, out_y, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_mode, out_ready,
    output in_ready, out_valid, out_w, out_x, out_y, out_z
  );
endinterface

// File: rtl/pattern_chain_pipe.sv
// Elastic chain of DEPTH registered pattern-3 cells with per-beat bypass and a 16-bit output MISR.
// Latency DEPTH cycles from input accept to out_valid; 1 beat/cycle with out_ready held high.
// Backpressure: combinational ready chain, stages compress on out_ready=0, in_ready drops only when all stages are full.
// Ports: blif_clk_net/blif_reset_net (sync, active-high); bus = in_*/out_* handshake bundle;
//        sig_clear clears the MISR; sig is the MISR value; occupancy counts valid stages.
module pattern_chain_pipe #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 3,
  parameter  int SIG_W = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                 blif_clk_net,
  input  logic                 blif_reset_net,
  pattern_chain_pipe_if.slave  bus,
  input  logic                 sig_clear,
  output logic [SIG_W-1:0]     sig,
  output logic [OCC_W-1:0]     occupancy
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(16'h100B);

  // Stage state: valid, mode and the stored (w,x,y,z) outputs of each cell.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] mode_q;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] x_q [DEPTH];
  logic [WIDTH-1:0] y_q [DEPTH];
  logic [WIDTH-1:0] z_q [DEPTH];
  logic [SIG_W-1:0] sig_q;

  // Per-stage load sources and next data.
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_vld;
  logic [DEPTH-1:0] src_mode;
  logic [WIDTH-1:0] src_a [DEPTH];
  logic [WIDTH-1:0] src_b [DEPTH];
  logic [WIDTH-1:0] src_c [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic [WIDTH-1:0] x_d   [DEPTH];
  logic [WIDTH-1:0] y_d   [DEPTH];
  logic [WIDTH-1:0] z_d   [DEPTH];

  logic                 out_hs;
  logic [4*WIDTH-1:0]   out_bus;
  logic [SIG_W-1:0]     fold;
  logic [SIG_W-1:0]     sig_d;
  logic [OCC_W-1:0]     occ;

  // ready_k = ~valid_k | ready_{k+1}, unrolled: stage k can load if the sink
  // is ready or any stage from k to the end has a hole to absorb the shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!valid_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  // Stage 0 is fed from the ports; stage k>0 from stage k-1 with (w,x,y,z)->(a,b,c,d).
  always_comb begin
    src_vld[0]  = bus.in_valid;
    src_mode[0] = bus.in_mode;
    src_a[0]    = bus.in_a;
    src_b[0]    = bus.in_b;
    src_c[0]    = bus.in_c;
    src_d[0]    = bus.in_d;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k]  = valid_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_a[k]    = w_q[k-1];
      src_b[k]    = x_q[k-1];
      src_c[k]    = y_q[k-1];
      src_d[k]    = z_q[k-1];
    end
  end

  // Pattern-3 cell, or pass-through when the beat is in bypass mode.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if (src_mode[k]) begin
        w_d[k] = src_a[k];
        x_d[k] = src_b[k];
        y_d[k] = src_c[k];
        z_d[k] = src_d[k];
      end else begin
        w_d[k] = ~(src_a[k] & ~src_c[k]);
        x_d[k] = ~(src_d[k] & ~src_b[k] & src_c[k]);
        y_d[k] = ~(src_d[k] & ~src_b[k] & ~src_a[k]);
        z_d[k] = src_b[k] | (src_a[k] & src_c[k] & ~src_d[k]);
      end
    end
  end

  // Fold the output word into SIG_W bits (implicit zero-extension of the last chunk).
  always_comb begin
    out_bus = {w_q[DEPTH-1], x_q[DEPTH-1], y_q[DEPTH-1], z_q[DEPTH-1]};
    fold    = '0;
    for (int i = 0; i < 4*WIDTH; i++) begin
      fold[i % SIG_W] = fold[i % SIG_W] ^ out_bus[i];
    end
  end

  // Clear beats update: a same-cycle handshake is folded into a zeroed register.
  always_comb begin
    out_hs = valid_q[DEPTH-1] & bus.out_ready;
    sig_d  = sig_q;
    if (sig_clear) begin
      sig_d = out_hs ? fold : '0;
    end else if (out_hs) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(valid_q[k]);
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      valid_q <= '0;
      mode_q  <= '0;
      sig_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        w_q[k] <= '0;
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) valid_q[k] <= src_vld[k];
        // Data only moves with a real beat; a bubble leaves the old data in place.
        if (rdy[k] && src_vld[k]) begin
          mode_q[k] <= src_mode[k];
          w_q[k]    <= w_d[k];
          x_q[k]    <= x_d[k];
          y_q[k]    <= y_d[k];
          z_q[k]    <= z_d[k];
        end
      end
      sig_q <= sig_d;
    end
  end

  assign bus.in_ready  = rdy[0] & ~blif_reset_net;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_w     = w_q[DEPTH-1];
  assign bus.out_x     = x_q[DEPTH-1];
  assign bus.out_y     = y_q[DEPTH-1];
  assign bus.out_z     = z_q[DEPTH-1];
  assign sig           = sig_q;
  assign occupancy     = occ;

endmodule

// File: tb/tb_pattern_chain_pipe.sv
// Directed bench for pattern_chain_pipe: DEPTH=3/WIDTH=4 and DEPTH=1/WIDTH=8 builds.
// Expected values are hand-computed from the cell equations and MISR polynomial.
module tb_pattern_chain_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr3 = 1'b0;
  logic        clr1 = 1'b0;
  logic [15:0] sig3;
  logic [15:0] sig1;
  logic [1:0]  occ3;
  logic [0:0]  occ1;

  int vectors = 0;
  int miscompares = 0;

  pattern_chain_pipe_if #(.WIDTH(4)) p ();
  pattern_chain_pipe_if #(.WIDTH(8)) q ();

  pattern_chain_pipe #(.WIDTH(4), .DEPTH(3), .SIG_W(16)) u_d3 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (p.slave),
    .sig_clear      (clr3),
    .sig            (sig3),
    .occupancy      (occ3)
  );

  pattern_chain_pipe #(.WIDTH(8), .DEPTH(1), .SIG_W(16)) u_d1 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (q.slave),
    .sig_clear      (clr1),
    .sig            (sig1),
    .occupancy      (occ1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic mode, input logic vld);
    p.in_a = a; p.in_b = b; p.in_c = c; p.in_d = d;
    p.in_mode = mode; p.in_valid = vld;
  endtask

  function automatic logic [31:0] out3();
    return {16'h0, p.out_w, p.out_x, p.out_y, p.out_z};
  endfunction

  // One beat through the idle 3-deep pipe with out_ready=1; checks latency, data and MISR.
  task automatic beat3(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input logic mode,
                       input logic clear, input logic [15:0] exp_out, input logic [15:0] exp_sig);
    drive3(a, b, c, d, mode, 1'b1);
    #1 chk({tag, "_in_ready"}, {31'h0, p.in_ready}, 32'd1);
    tick;                       // edge T: accepted
    p.in_valid = 1'b0;
    chk({tag, "_vld_T"}, {31'h0, p.out_valid}, 32'd0);
    tick;                       // edge T+1
    chk({tag, "_vld_T1"}, {31'h0, p.out_valid}, 32'd0);
    tick;                       // edge T+2: at output
    chk({tag, "_vld_T2"}, {31'h0, p.out_valid}, 32'd1);
    chk({tag, "_out"}, out3(), {16'h0, exp_out});
    clr3 = clear;
    tick;                       // edge T+3: handshake
    clr3 = 1'b0;
    chk({tag, "_sig"}, {16'h0, sig3}, {16'h0, exp_sig});
    chk({tag, "_drained"}, {31'h0, p.out_valid}, 32'd0);
  endtask

  initial begin
    drive3(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    p.out_ready = 1'b0;
    q.in_a = '0; q.in_b = '0; q.in_c = '0; q.in_d = '0;
    q.in_mode = 1'b0; q.in_valid = 1'b0; q.out_ready = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_out_valid", {31'h0, p.out_valid}, 32'd0);
    chk("rst_occ", {30'h0, occ3}, 32'd0);
    chk("rst_in_ready", {31'h0, p.in_ready}, 32'd0);
    chk("rst_sig", {16'h0, sig3}, 32'd0);
    chk("rst_data", out3(), 32'd0);
    chk("rst_sig_d1", {16'h0, sig1}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'h0, p.in_ready}, 32'd1);

    // Single beats, MISR sequence FFFF -> 100A -> clear+beat FFFF -> EFF5
    p.out_ready = 1'b1;
    beat3("b1_f0f0", 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    beat3("b2_zero", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'hFFFF, 16'h100A);
    beat3("b3_clr",  4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    beat3("b4_byp",  4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'hEFF5);

    // Backpressure: 5 bypass beats offered, only 3 fit
    p.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive3(4'(i), 4'(i), 4'(i), 4'(i), 1'b1, 1'b1);
      #1 chk($sformatf("bp_in_ready_%0d", i), {31'h0, p.in_ready}, (i <= 3) ? 32'd1 : 32'd0);
      tick;
      chk($sformatf("bp_occ_%0d", i), {30'h0, occ3}, (i < 3) ? 32'(i) : 32'd3);
    end
    chk("bp_hold_out", out3(), 32'h1111);
    tick;
    chk("bp_stable_out", out3(), 32'h1111);

    // Full pipe, drain and accept on the same edge
    p.out_ready = 1'b1;
    drive3(4'h6, 4'h6, 4'h6, 4'h6, 1'b1, 1'b1);
    #1 chk("full_in_ready", {31'h0, p.in_ready}, 32'd1);
    tick;
    p.in_valid = 1'b0;
    chk("full_occ", {30'h0, occ3}, 32'd3);
    chk("drain_b2", out3(), 32'h2222);
    tick;
    chk("drain_b3", out3(), 32'h3333);
    chk("drain_occ2", {30'h0, occ3}, 32'd2);
    tick;
    chk("drain_b6", out3(), 32'h6666);
    chk("drain_occ1", {30'h0, occ3}, 32'd1);
    tick;
    chk("drain_empty", {31'h0, p.out_valid}, 32'd0);
    chk("drain_occ0", {30'h0, occ3}, 32'd0);

    // Reset mid-stream with two beats in flight
    p.out_ready = 1'b0;
    drive3(4'h7, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1);
    tick;
    drive3(4'h8, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1);
    tick;
    p.in_valid = 1'b0;
    chk("mid_occ2", {30'h0, occ3}, 32'd2);
    rst = 1'b1;
    tick;
    chk("mid_rst_occ", {30'h0, occ3}, 32'd0);
    chk("mid_rst_valid", {31'h0, p.out_valid}, 32'd0);
    chk("mid_rst_sig", {16'h0, sig3}, 32'd0);
    chk("mid_rst_in_ready", {31'h0, p.in_ready}, 32'd0);
    rst = 1'b0;
    p.out_ready = 1'b1;
    tick; tick; tick;
    chk("mid_no_stale", {31'h0, p.out_valid}, 32'd0);
    chk("mid_no_stale_occ", {30'h0, occ3}, 32'd0);

    // DEPTH=1, WIDTH=8 build
    q.out_ready = 1'b1;
    q.in_a = 8'h0F; q.in_b = 8'h00; q.in_c = 8'h0F; q.in_d = 8'h00;
    q.in_mode = 1'b0; q.in_valid = 1'b1;
    #1 chk("d1_in_ready", {31'h0, q.in_ready}, 32'd1);
    tick;
    q.in_valid = 1'b0;
    chk("d1_valid", {31'h0, q.out_valid}, 32'd1);
    chk("d1_occ", {31'h0, occ1}, 32'd1);
    chk("d1_out", {q.out_w, q.out_x, q.out_y, q.out_z}, 32'hFFFF_FF0F);
    tick;
    chk("d1_sig_fold", {16'h0, sig1}, 32'h0000_00F0);
    chk("d1_drained", {31'h0, q.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
